// File: rtl/uart_cmd_master.sv
// Initiator for the uart_mcu byte command protocol: sends cmd/data bytes and collects response bytes.
// Define CMD_MASTER_CHECKSUM_EN to verify the long-read sum byte (err on mismatch).
module uart_cmd_master #(
    parameter int BYTE_GAP = 600,
    parameter int TIMEOUT  = 65535,
    parameter int LONG_LEN = 1024
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_kind,
    input  logic [7:0] req_cmd,
    input  logic [7:0] req_data,
    output logic       tx_send,
    output logic [7:0] tx_data,
    input  logic       rx_rec,
    input  logic [7:0] rx_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_last,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, SEND_CMD, GAP, SEND_DATA, WAIT_RSP, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  kind_q, kind_d;
    logic [7:0]  data_q, data_d;
    logic        data_sent_q, data_sent_d;
    logic [31:0] gap_q, gap_d;
    logic [31:0] to_q, to_d;
    logic [10:0] cnt_q, cnt_d;
    logic        bad_q, bad_d;
    logic        rx_rec_q, rx_rec_d;
`ifdef CMD_MASTER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif
    logic        req_ready_q, req_ready_d;
    logic        tx_send_q, tx_send_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_last_q, rsp_last_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        rx_edge;

    assign rx_rec_d = rx_rec;
    assign rx_edge  = rx_rec & ~rx_rec_q;

    always_comb begin
        logic gap_step;
        gap_step    = 1'b0;
        state_d     = state_q;
        kind_d      = kind_q;
        data_d      = data_q;
        data_sent_d = data_sent_q;
        gap_d       = gap_q;
        to_d        = to_q;
        cnt_d       = cnt_q;
        bad_d       = bad_q;
`ifdef CMD_MASTER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        req_ready_d = req_ready_q;
        tx_send_d   = 1'b0;
        tx_data_d   = tx_data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    kind_d      = req_kind;
                    data_d      = req_data;
                    data_sent_d = 1'b0;
                    gap_d       = '0;
                    to_d        = '0;
                    cnt_d       = '0;
                    bad_d       = 1'b0;
`ifdef CMD_MASTER_CHECKSUM_EN
                    sum_d       = '0;
`endif
                    req_ready_d = 1'b0;
                    tx_send_d   = 1'b1;
                    tx_data_d   = req_cmd;
                    state_d     = SEND_CMD;
                end
            end
            SEND_CMD: begin
                if (kind_q[1]) begin
                    to_d    = to_q + 32'd1;
                    state_d = WAIT_RSP;
                end else begin
                    gap_step = 1'b1;
                end
            end
            GAP, SEND_DATA: gap_step = 1'b1;
            WAIT_RSP: begin
                // A byte arriving on the last timeout cycle is still accepted.
                if (rx_edge) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_data;
                    to_d        = '0;
                    if (kind_q == 2'd2 || cnt_q == 11'(LONG_LEN)) begin
                        rsp_last_d = 1'b1;
                        state_d    = DONE;
`ifdef CMD_MASTER_CHECKSUM_EN
                        bad_d      = (kind_q == 2'd3) && (rx_data != sum_q);
`endif
                    end else begin
                        cnt_d = cnt_q + 11'd1;
`ifdef CMD_MASTER_CHECKSUM_EN
                        sum_d = sum_q + rx_data;
`endif
                    end
                end else if (to_q == 32'(TIMEOUT - 1)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    to_d = to_q + 32'd1;
                end
            end
            DONE: begin
                // Entered with done already pulsing (gap/timeout) or one cycle after the last byte.
                if (done_q) begin
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    done_d = 1'b1;
                    err_d  = bad_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (gap_step) begin
            if (gap_q == 32'(BYTE_GAP - 1)) begin
                gap_d = '0;
                if (kind_q == 2'd1 && !data_sent_q) begin
                    tx_send_d   = 1'b1;
                    tx_data_d   = data_q;
                    data_sent_d = 1'b1;
                    state_d     = SEND_DATA;
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end else begin
                gap_d   = gap_q + 32'd1;
                state_d = GAP;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            kind_q      <= '0;
            data_q      <= '0;
            data_sent_q <= 1'b0;
            gap_q       <= '0;
            to_q        <= '0;
            cnt_q       <= '0;
            bad_q       <= 1'b0;
            rx_rec_q    <= 1'b0;
`ifdef CMD_MASTER_CHECKSUM_EN
            sum_q       <= '0;
`endif
            req_ready_q <= 1'b1;
            tx_send_q   <= 1'b0;
            tx_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            data_q      <= data_d;
            data_sent_q <= data_sent_d;
            gap_q       <= gap_d;
            to_q        <= to_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            rx_rec_q    <= rx_rec_d;
`ifdef CMD_MASTER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
            req_ready_q <= req_ready_d;
            tx_send_q   <= tx_send_d;
            tx_data_q   <= tx_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_send   = tx_send_q;
    assign tx_data   = tx_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: whole run is planned up front as per-cycle expected outputs and input schedule.
module tb_uart_cmd_master;
    localparam int G    = 8;
    localparam int TO   = 100;
    localparam int LL   = 4;
    localparam int MAXC = 20000;
`ifdef CMD_MASTER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       sys_clk, sys_rst, req_valid, req_ready;
    logic [1:0] req_kind;
    logic [7:0] req_cmd, req_data, tx_data, rx_data, rsp_data;
    logic       tx_send, rx_rec, rsp_valid, rsp_last, done, err;

    uart_cmd_master #(.BYTE_GAP(G), .TIMEOUT(TO), .LONG_LEN(LL)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_cmd(req_cmd), .req_data(req_data),
        .tx_send(tx_send), .tx_data(tx_data),
        .rx_rec(rx_rec), .rx_data(rx_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .done(done), .err(err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Expected outputs per cycle (cycle = posedge count seen at the negedge sample).
    bit         exp_tx_v[MAXC];
    logic [7:0] exp_tx_d[MAXC];
    bit         exp_rsp_v[MAXC];
    logic [7:0] exp_rsp_d[MAXC];
    bit         exp_rsp_l[MAXC];
    bit         exp_done[MAXC];
    bit         exp_err[MAXC];
    bit         exp_busy[MAXC];
    // Inputs applied just after the negedge of each cycle.
    bit         in_rst[MAXC];
    bit         in_reqv[MAXC];
    logic [1:0] in_kind[MAXC];
    logic [7:0] in_cmd[MAXC];
    logic [7:0] in_dat[MAXC];
    bit         in_rx[MAXC];
    logic [7:0] in_rxd[MAXC];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, c, act, exp);
        end
    endtask

    typedef struct {int c; logic [7:0] d; logic l;} ev_t;
    ev_t q_tx[$];
    ev_t q_rsp[$];
    ev_t q_done[$];
    bit running = 1'b0;
    logic [7:0] last_tx = 8'h00;

    always @(negedge sys_clk) begin
        if (running && cyc > 0 && cyc < MAXC) begin
            if (in_rst[cyc-1]) last_tx = 8'h00;
            if (exp_tx_v[cyc]) last_tx = exp_tx_d[cyc];
            chk("req_ready", cyc, req_ready, !exp_busy[cyc]);
            chk("tx_send", cyc, tx_send, exp_tx_v[cyc]);
            chk("tx_data", cyc, tx_data, last_tx);
            chk("rsp_valid", cyc, rsp_valid, exp_rsp_v[cyc]);
            if (exp_rsp_v[cyc]) chk("rsp_data", cyc, rsp_data, exp_rsp_d[cyc]);
            chk("rsp_last", cyc, rsp_last, exp_rsp_v[cyc] & exp_rsp_l[cyc]);
            chk("done", cyc, done, exp_done[cyc]);
            chk("err", cyc, err, exp_done[cyc] & exp_err[cyc]);
            if (tx_send)   q_tx.push_back('{cyc, tx_data, 1'b0});
            if (rsp_valid) q_rsp.push_back('{cyc, rsp_data, rsp_last});
            if (done)      q_done.push_back('{cyc, 8'h00, err});
        end
    end

    int ready_at, last_p, last_d;
    logic [7:0] rb[$];
    int dl[$];

    // Model: dl[i] is the cycle distance from the cmd pulse (or previous response) to response i.
    task automatic plan(input logic [1:0] kind, input logic [7:0] cmd, input logic [7:0] dat,
                        input int early, input int idle, input bit spur);
        int present, k, p, d, r, v, h, n;
        bit to_hit;
        logic [7:0] s;
        present = (early > 0) ? ready_at - early : ready_at + idle;
        k = (present > ready_at) ? present : ready_at;
        for (int c = present; c <= k; c++) begin
            in_reqv[c] = 1'b1; in_kind[c] = kind; in_cmd[c] = cmd; in_dat[c] = dat;
        end
        p = k + 1;
        exp_tx_v[p] = 1'b1; exp_tx_d[p] = cmd;
        d = p;
        if (kind == 2'd0) begin
            d = p + G;
            exp_done[d] = 1'b1;
        end else if (kind == 2'd1) begin
            exp_tx_v[p+G] = 1'b1; exp_tx_d[p+G] = dat;
            d = p + 2*G;
            exp_done[d] = 1'b1;
        end else begin
            r = p; n = rb.size(); s = 8'h00; to_hit = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (!to_hit) begin
                    if (dl[i] > TO) begin
                        to_hit = 1'b1;
                        d = r + TO;
                        exp_done[d] = 1'b1; exp_err[d] = 1'b1;
                    end else begin
                        v = r + dl[i];
                        h = int'($urandom_range(1, 2));
                        for (int j = 0; j < h; j++) begin
                            in_rx[v-1+j] = 1'b1; in_rxd[v-1+j] = rb[i];
                        end
                        exp_rsp_v[v] = 1'b1; exp_rsp_d[v] = rb[i]; exp_rsp_l[v] = (i == n-1);
                        if (i < n-1) s = s + rb[i];
                        r = v;
                    end
                end
            end
            if (!to_hit) begin
                d = r + 1;
                exp_done[d] = 1'b1;
                exp_err[d] = CK && (kind == 2'd3) && (rb[n-1] != s);
            end
        end
        if (spur && kind < 2) begin
            in_rx[p+2] = 1'b1; in_rxd[p+2] = 8'hEE;
        end
        for (int c = p; c <= d; c++) exp_busy[c] = 1'b1;
        last_p = p; last_d = d; ready_at = d + 1;
    endtask

    task automatic abort_at(input int x);
        for (int c = x + 1; c <= last_d; c++) begin
            exp_tx_v[c] = 1'b0; exp_rsp_v[c] = 1'b0; exp_done[c] = 1'b0;
            exp_busy[c] = 1'b0; in_rx[c] = 1'b0;
        end
        in_rst[x] = 1'b1; in_rst[x+1] = 1'b1;
        ready_at = x + 2;
    endtask

    initial begin
        logic [1:0] kind;
        logic [7:0] b, s;
        int n, r, e, end_c;
        sys_rst = 1'b1; req_valid = 1'b0; req_kind = 2'd0; req_cmd = 8'h00; req_data = 8'h00;
        rx_rec = 1'b0; rx_data = 8'h00;
        for (int c = 0; c < 4; c++) in_rst[c] = 1'b1;
        ready_at = 5;

        // Directed cases first; the literal checks below index into their events.
        rb.delete(); dl.delete();
        plan(2'd0, 8'h10, 8'h00, 0, 0, 1'b0);
        plan(2'd1, 8'h30, 8'h5A, 0, 1, 1'b0);
        rb = '{8'hC3}; dl = '{5};
        plan(2'd2, 8'h20, 8'h00, 0, 0, 1'b0);
        rb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A}; dl = '{4, 5, 6, 4, 7};
        plan(2'd3, 8'hA3, 8'h00, 0, 2, 1'b0);
        rb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        plan(2'd3, 8'hA3, 8'h00, 0, 0, 1'b0);
        rb = '{8'h00}; dl = '{TO + 1};
        plan(2'd2, 8'h21, 8'h00, 0, 0, 1'b0);
        rb = '{8'h77}; dl = '{TO};
        plan(2'd2, 8'h22, 8'h00, 0, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            if (ready_at < MAXC - 1200) begin
                kind = 2'($urandom_range(0, 3));
                rb.delete(); dl.delete(); s = 8'h00;
                if (kind >= 2'd2) begin
                    n = (kind == 2'd2) ? 1 : LL + 1;
                    for (int i = 0; i < n; i++) begin
                        if (kind == 2'd3 && i == n-1)
                            b = ($urandom_range(0, 3) == 0) ? (s ^ 8'($urandom_range(1, 255))) : s;
                        else begin
                            b = 8'($urandom); s = s + b;
                        end
                        rb.push_back(b);
                        r = int'($urandom_range(0, 24));
                        dl.push_back(r == 0 ? TO + 1 : (r == 1 ? TO : int'($urandom_range(4, 12))));
                    end
                end
                e = int'($urandom_range(0, 1));
                plan(kind, (kind == 2'd3) ? 8'hA3 : 8'($urandom), 8'($urandom),
                     e ? int'($urandom_range(1, 3)) : 0, e ? 0 : int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
            end
        end

        // Reset in the middle of a long read, then a normal readback.
        rb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA}; dl = '{6, 6, 6, 6, 6};
        plan(2'd3, 8'hA3, 8'h00, 0, 2, 1'b0);
        abort_at(last_p + 14);
        rb = '{8'h5C}; dl = '{5};
        plan(2'd2, 8'h24, 8'h00, 0, 0, 1'b0);

        end_c = ready_at + 4;
        running = 1'b1;
        while (cyc < end_c) begin
            @(negedge sys_clk);
            #1;
            sys_rst   = in_rst[cyc];
            req_valid = in_reqv[cyc];
            if (in_reqv[cyc]) begin
                req_kind = in_kind[cyc]; req_cmd = in_cmd[cyc]; req_data = in_dat[cyc];
            end
            rx_rec = in_rx[cyc];
            if (in_rx[cyc]) rx_data = in_rxd[cyc];
        end
        running = 1'b0;

        if (q_tx.size() < 8 || q_rsp.size() < 12 || q_done.size() < 9) begin
            total++; bad++;
            $display("FAIL directed_events tx=%0d rsp=%0d done=%0d want at least 8/12/9",
                     q_tx.size(), q_rsp.size(), q_done.size());
        end else begin
            chk("t1_cmd", q_tx[0].c, q_tx[0].d, 8'h10);
            chk("t1_done_delay", q_done[0].c, q_done[0].c - q_tx[0].c, 8);
            chk("t1_err", q_done[0].c, q_done[0].l, 1'b0);
            chk("t2_cmd", q_tx[1].c, q_tx[1].d, 8'h30);
            chk("t2_data", q_tx[2].c, q_tx[2].d, 8'h5A);
            chk("t2_spacing", q_tx[2].c, q_tx[2].c - q_tx[1].c, 8);
            chk("t2_done_delay", q_done[1].c, q_done[1].c - q_tx[2].c, 8);
            chk("t3_rsp", q_rsp[0].c, q_rsp[0].d, 8'hC3);
            chk("t3_last", q_rsp[0].c, q_rsp[0].l, 1'b1);
            chk("t3_done_after_rsp", q_done[2].c, q_done[2].c - q_rsp[0].c, 1);
            chk("t4_penult_last", q_rsp[4].c, q_rsp[4].l, 1'b0);
            chk("t4_sum_byte", q_rsp[5].c, q_rsp[5].d, 8'h0A);
            chk("t4_sum_last", q_rsp[5].c, q_rsp[5].l, 1'b1);
            chk("t4_err", q_done[3].c, q_done[3].l, 1'b0);
            chk("t4_bad_sum_err", q_done[4].c, q_done[4].l, CK);
            chk("t5_timeout_err", q_done[5].c, q_done[5].l, 1'b1);
            chk("t5_timeout_delay", q_done[5].c, q_done[5].c - q_tx[6].c, 100);
            chk("t5_edge_byte_delay", q_rsp[11].c, q_rsp[11].c - q_tx[7].c, 100);
            chk("t5_edge_byte_err", q_done[6].c, q_done[6].l, 1'b0);
            chk("t6_after_reset_rsp", q_rsp[$].c, q_rsp[$].d, 8'h5C);
            chk("t6_after_reset_err", q_done[$].c, q_done[$].l, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
